cardinal_nic: RTL and testbench

Network interface controller joining one Cardinal processor's NIC register port to its ring router. The processor sees four 64-bit registers: the input channel buffer, input status, output channel buffer and output status. The router sees two single-entry channels with a ready/send handshake. Each ring node in `cardinal_cmp` has one instance, sitting between the CPU's NIC port and the router's processor-side port.

---
 rtl/cardinal_pkg.sv | 28 ++
 rtl/cardinal_nic_if.sv | 28 ++
 rtl/nic_chan_buf.sv | 33 +++
 rtl/cardinal_nic.sv | 62 ++++++
 tb/tb_cardinal_nic.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/cardinal_pkg.sv
// Shared Cardinal definitions: NIC register map, packet field positions and word type.
// Packets use MSB-0 numbering, so bit 0 (the VC bit) is the most significant bit.
package cardinal_pkg;

  localparam int unsigned DATA_W = 64;

  localparam logic [1:0] NIC_IBUF  = 2'b00;
  localparam logic [1:0] NIC_ISTAT = 2'b01;
  localparam logic [1:0] NIC_OBUF  = 2'b10;
  localparam logic [1:0] NIC_OSTAT = 2'b11;

  localparam int unsigned PKT_VC      = 0;
  localparam int unsigned PKT_DIR_LO  = 1;
  localparam int unsigned PKT_DIR_HI  = 2;
  localparam int unsigned PKT_HOP_LO  = 8;
  localparam int unsigned PKT_HOP_HI  = 15;
  localparam int unsigned PKT_SRC_LO  = 16;
  localparam int unsigned PKT_SRC_HI  = 23;
  localparam int unsigned PKT_DATA_LO = 32;
  localparam int unsigned PKT_DATA_HI = 63;

  typedef logic [0:DATA_W-1] word_t;

  function automatic logic pkt_vc(word_t pkt);
    return pkt[PKT_VC];
  endfunction

endpackage

// File: rtl/cardinal_nic_if.sv
// Processor register port and router channel signals of one Cardinal NIC.
interface cardinal_nic_if;
  import cardinal_pkg::*;

  logic [1:0] addr;
  word_t      d_in;
  word_t      d_out;
  logic       nicEn;
  logic       nicWrEn;
  logic       net_si;
  logic       net_ri;
  word_t      net_di;
  logic       net_so;
  logic       net_ro;
  word_t      net_do;
  logic       net_polarity;

  modport slave (
    input  addr, d_in, nicEn, nicWrEn, net_si, net_di, net_ro, net_polarity,
    output d_out, net_ri, net_so, net_do
  );

  modport master (
    output addr, d_in, nicEn, nicWrEn, net_si, net_di, net_ro, net_polarity,
    input  d_out, net_ri, net_so, net_do
  );

endinterface

// File: rtl/nic_chan_buf.sv
// Single-entry channel buffer with full flag; a load is taken only while empty.
module nic_chan_buf
  import cardinal_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  ld,
  input  word_t din,
  input  logic  clr,
  output word_t dout,
  output logic  full
);

  word_t data_q;
  logic  full_q;

  // Clearing only drops the flag; the stale data stays readable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else if (ld && !full_q) begin
      data_q <= din;
      full_q <= 1'b1;
    end else if (clr) begin
      full_q <= 1'b0;
    end
  end

  assign dout = data_q;
  assign full = full_q;

endmodule

// File: rtl/cardinal_nic.sv
// Cardinal NIC: four processor-visible registers bridging to the ring router channels.
module cardinal_nic
  import cardinal_pkg::*;
(
  input logic           clk,
  input logic           reset,
  cardinal_nic_if.slave nic
);

  word_t ibuf;
  word_t obuf;
  logic  ifull;
  logic  ofull;
  logic  rd_en;
  logic  rd_ibuf;
  logic  wr_obuf;
  logic  send;

  assign rd_en   = nic.nicEn && !nic.nicWrEn;
  assign rd_ibuf = rd_en && (nic.addr == NIC_IBUF);
  assign wr_obuf = nic.nicEn && nic.nicWrEn && (nic.addr == NIC_OBUF);
  // A packet may leave only in the ring phase matching its VC bit.
  assign send    = ofull && nic.net_ro && (pkt_vc(obuf) == nic.net_polarity);

  nic_chan_buf u_in_chan (
    .clk   (clk),
    .reset (reset),
    .ld    (nic.net_si),
    .din   (nic.net_di),
    .clr   (rd_ibuf),
    .dout  (ibuf),
    .full  (ifull)
  );

  nic_chan_buf u_out_chan (
    .clk   (clk),
    .reset (reset),
    .ld    (wr_obuf),
    .din   (nic.d_in),
    .clr   (send),
    .dout  (obuf),
    .full  (ofull)
  );

  always_comb begin
    nic.d_out = '0;
    if (rd_en) begin
      unique case (nic.addr)
        NIC_IBUF:  nic.d_out = ibuf;
        NIC_ISTAT: nic.d_out = {{(DATA_W-1){1'b0}}, ifull};
        NIC_OBUF:  nic.d_out = obuf;
        NIC_OSTAT: nic.d_out = {{(DATA_W-1){1'b0}}, ofull};
        default:   nic.d_out = '0;
      endcase
    end
  end

  assign nic.net_ri = ~ifull;
  assign nic.net_so = send;
  assign nic.net_do = obuf;

endmodule

// File: tb/tb_cardinal_nic.sv
// Self-checking bench for cardinal_nic: register table plus send/receive/reset sequences.
module tb_cardinal_nic;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;
  logic [63:0] exp_q[$];

  cardinal_nic_if bus ();

  cardinal_nic dut (
    .clk   (clk),
    .reset (reset),
    .nic   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [1:0]  addr;
    logic        si;
    logic [63:0] di;
    logic [63:0] exp_dout;
    logic        exp_ri;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; polarity flips each cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    bus.net_polarity = ~bus.net_polarity;
  endtask

  task automatic rd(input logic [1:0] a);
    bus.nicEn   = 1'b1;
    bus.nicWrEn = 1'b0;
    bus.addr    = a;
  endtask

  task automatic wr(input logic [1:0] a, input logic [63:0] d);
    bus.nicEn   = 1'b1;
    bus.nicWrEn = 1'b1;
    bus.addr    = a;
    bus.d_in    = d;
  endtask

  // Scoreboard: every emitted packet must match the oldest expected one.
  always @(negedge clk) begin
    if (!reset && bus.net_so === 1'b1) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_send: got packet %h, expected no send", bus.net_do);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        if (bus.net_do !== e) begin
          n_fail++;
          $display("FAIL sb_send: got %h, expected %h", bus.net_do, e);
        end
      end
    end
  end

  initial begin
    logic sent;
    n_tests = 0;
    n_fail  = 0;

    vecs[0] = '{en: 1'b0, addr: 2'b00, si: 1'b0, di: 64'h0, exp_dout: 64'h0,    exp_ri: 1'b0};
    vecs[1] = '{en: 1'b1, addr: 2'b01, si: 1'b0, di: 64'h0, exp_dout: 64'h1,    exp_ri: 1'b0};
    vecs[2] = '{en: 1'b1, addr: 2'b11, si: 1'b0, di: 64'h0, exp_dout: 64'h1,    exp_ri: 1'b0};
    vecs[3] = '{en: 1'b1, addr: 2'b10, si: 1'b0, di: 64'h0,
                exp_dout: 64'h0000_0000_CAFE_F00D, exp_ri: 1'b0};
    // Read-clear while the router sends: no capture that cycle.
    vecs[4] = '{en: 1'b1, addr: 2'b00, si: 1'b1, di: 64'h7777,
                exp_dout: 64'h1234, exp_ri: 1'b0};
    vecs[5] = '{en: 1'b1, addr: 2'b01, si: 1'b0, di: 64'h0, exp_dout: 64'h0,    exp_ri: 1'b1};
    vecs[6] = '{en: 1'b1, addr: 2'b00, si: 1'b0, di: 64'h0, exp_dout: 64'h1234, exp_ri: 1'b1};
    vecs[7] = '{en: 1'b1, addr: 2'b01, si: 1'b0, di: 64'h0, exp_dout: 64'h0,    exp_ri: 1'b1};

    reset            = 1'b1;
    bus.addr         = 2'b01;
    bus.d_in         = '0;
    bus.nicEn        = 1'b1;
    bus.nicWrEn      = 1'b0;
    bus.net_si       = 1'b0;
    bus.net_di       = '0;
    bus.net_ro       = 1'b0;
    bus.net_polarity = 1'b0;

    #2;
    chk("rst_dout", bus.d_out, 64'h0);
    chk("rst_ri", {63'h0, bus.net_ri}, 64'h1);
    chk("rst_so", {63'h0, bus.net_so}, 64'h0);
    chk("rst_do", bus.net_do, 64'h0);
    tick();
    tick();
    reset = 1'b0;
    rd(2'b01);
    #1 chk("post_rst_istat", bus.d_out, 64'h0);
    rd(2'b11);
    #1 chk("post_rst_ostat", bus.d_out, 64'h0);

    // Send on matching phase: write while polarity is 0.
    for (int i = 0; i < 2 && bus.net_polarity; i++) tick();
    bus.net_ro = 1'b1;
    wr(2'b10, 64'h0000_0000_DEAD_BEEF);
    exp_q.push_back(64'h0000_0000_DEAD_BEEF);
    tick();
    rd(2'b11);
    #1;
    chk("send_wrong_phase_so", {63'h0, bus.net_so}, 64'h0);
    chk("send_ofull", bus.d_out, 64'h1);
    tick();
    #1;
    chk("send_match_so", {63'h0, bus.net_so}, 64'h1);
    chk("send_do", bus.net_do, 64'h0000_0000_DEAD_BEEF);
    tick();
    #1;
    chk("send_ostat_after", bus.d_out, 64'h0);

    // Back-pressure and dropped write.
    bus.net_ro = 1'b0;
    wr(2'b10, 64'h8000_0000_0000_0001);
    exp_q.push_back(64'h8000_0000_0000_0001);
    for (int i = 0; i < 6; i++) begin
      tick();
      rd(2'b11);
      #1;
      chk("bp_so", {63'h0, bus.net_so}, 64'h0);
      chk("bp_ofull", bus.d_out, 64'h1);
    end
    tick();
    wr(2'b10, 64'hAAAA_AAAA_AAAA_AAAA);
    tick();
    rd(2'b10);
    #1 chk("bp_obuf_kept", bus.d_out, 64'h8000_0000_0000_0001);
    sent = 1'b0;
    for (int i = 0; i < 4 && !sent; i++) begin
      tick();
      bus.net_ro = 1'b1;
      #1;
      chk("bp_so_phase", {63'h0, bus.net_so}, {63'h0, bus.net_polarity});
      if (bus.net_so === 1'b1) sent = 1'b1;
    end
    if (!sent) begin
      n_tests++;
      n_fail++;
      $display("FAIL bp_send_timeout: got no send, expected one within 4 cycles");
    end
    tick();
    bus.net_ro = 1'b0;
    rd(2'b11);
    #1 chk("bp_ostat_after", bus.d_out, 64'h0);

    // Router to NIC capture, then a send into a full channel.
    bus.nicEn  = 1'b0;
    bus.net_si = 1'b1;
    bus.net_di = 64'h1234;
    #1 chk("cap_ri_before", {63'h0, bus.net_ri}, 64'h1);
    tick();
    bus.net_si = 1'b0;
    #1 chk("cap_ri_after", {63'h0, bus.net_ri}, 64'h0);
    tick();
    bus.net_si = 1'b1;
    bus.net_di = 64'hFFFF;
    tick();
    bus.net_si = 1'b0;
    wr(2'b10, 64'h0000_0000_CAFE_F00D);
    exp_q.push_back(64'h0000_0000_CAFE_F00D);

    for (int i = 0; i < 8; i++) begin
      tick();
      bus.nicEn   = vecs[i].en;
      bus.nicWrEn = 1'b0;
      bus.addr    = vecs[i].addr;
      bus.net_si  = vecs[i].si;
      bus.net_di  = vecs[i].di;
      #1;
      chk($sformatf("vec%0d_dout", i), bus.d_out, vecs[i].exp_dout);
      chk($sformatf("vec%0d_ri", i), {63'h0, bus.net_ri}, {63'h0, vecs[i].exp_ri});
    end

    // Reset mid-operation with both channels full.
    tick();
    bus.net_si = 1'b1;
    bus.net_di = 64'h5555;
    tick();
    bus.net_si = 1'b0;
    rd(2'b11);
    #1;
    chk("mid_ri_full", {63'h0, bus.net_ri}, 64'h0);
    chk("mid_ofull", bus.d_out, 64'h1);
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_so", {63'h0, bus.net_so}, 64'h0);
    chk("mid_rst_ri", {63'h0, bus.net_ri}, 64'h1);
    chk("mid_rst_ostat", bus.d_out, 64'h0);
    exp_q.delete();
    tick();
    tick();
    reset = 1'b0;
    rd(2'b01);
    #1 chk("mid_post_istat", bus.d_out, 64'h0);
    rd(2'b11);
    #1 chk("mid_post_ostat", bus.d_out, 64'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      bus.net_ro = 1'b1;
      #1 chk("mid_no_resend", {63'h0, bus.net_so}, 64'h0);
    end
    tick();
    chk("sb_drained", 64'(exp_q.size()), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
